mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have these ports: clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have these ports: rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-003 rdy_in  input  1  global enable; low freezes all state.
REQ-004 clear  input  1  misprediction flush from ROB.
REQ-005 if_req  input  1  fetch request, held high until if_done; if_addr  input  32  fetch byte address.
REQ-006 if_done  output  1  one-cycle pulse, fetch complete; if_data  output  32  fetched word, little-endian.
REQ-007 lsb_req  input  1  LSB request, held until lsb_done; lsb_wr  input  1  1=store, 0=load.
REQ-008 lsb_addr  input  32; lsb_len  input  2  0=byte, 1=half, 2=word; 3 is treated as word; lsb_wdata  input  32.
REQ-009 lsb_done  output  1  one-cycle pulse; lsb_rdata  output  32  load data, zero-extended.
REQ-010 mem_din  input  8  RAM read byte; mem_dout  output  8; mem_a  output  32; mem_wr  output  1  1=write.
REQ-011 io_buffer_full  input  1  UART buffer full.

Function
REQ-012 States: IDLE, READ, WRITE. Byte counter is 3 bits; N = 1, 2 or 4 bytes.
REQ-013 IDLE with both requests pending: the LSB request SHALL win. IF is accepted only when lsb_req is low.
REQ-014 A request is accepted in cycle 0.
  - mem_a = addr+i in cycles 1..N.
  - The RAM returns the byte for mem_a driven in cycle c on mem_din in cycle c+1.
  - Bytes are sampled in cycles 2..N+1.
REQ-015 Reads: done and data are asserted together in cycle N+2; word fetch/load latency is 6 cycles from accept.
  - Byte i goes to data bits [8i+7:8i]; unused upper bytes are 0.
REQ-016 Writes: mem_wr=1 and mem_dout = lsb_wdata byte i with mem_a = addr+i in cycles 1..N; lsb_done is asserted in cycle N+1.
REQ-017 mem_wr SHALL be 0 in every cycle that is not a write-byte cycle, including IDLE and READ.
REQ-018 After done, the state SHALL be IDLE; a new request can be accepted in the cycle after done.
  - The requester must deassert req in the done cycle, or it is re-accepted.
REQ-019 if_data/lsb_rdata SHALL hold their last value until the next done of the same port.
REQ-020 clear high in IDLE: no request is accepted that cycle.
REQ-021 clear high during an IF read or LSB read: abort, go to IDLE next cycle, no done pulse.
REQ-022 clear high during an LSB write: ignored; the write completes with lsb_done.
REQ-023 rdy_in low: all registers hold; mem_wr output forced to 0; the transfer resumes unchanged when rdy_in returns high.
REQ-024 mem_a arithmetic is 32-bit and wraps from 0xFFFFFFFF to 0.

Reset
REQ-025 rst_in low SHALL immediately force:
  - state=IDLE, counter=0
  - if_done=0, lsb_done=0, mem_wr=0
  - mem_a=0, mem_dout=0, if_data=0, lsb_rdata=0
REQ-026 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first accept can occur in the first cycle after rst_in rises.

Configuration
REQ-027 Macro MEM_CTRL_IO_STALL_EN.
  - Defined: an LSB store to address 0x00030000 or 0x00030004 SHALL NOT be accepted while io_buffer_full=1. IF requests may be accepted meanwhile.
  - Undefined: io_buffer_full is ignored.

Verification
REQ-028 Word fetch: if_req with if_addr=0x100 and RAM bytes 13,00,00,93 -> mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_data=0x93000013.
REQ-029 Concurrent requests: if_req and lsb_req load byte 0x200 (RAM 0xFF) raised the same cycle -> LSB first, lsb_done cycle 3 with lsb_rdata=0x000000FF; then IF accepted cycle 4, if_done cycle 10.
REQ-030 Half store: lsb_addr=0x400, lsb_wdata=0xAABBCCDD -> mem_wr=1 with (0x400,DD) and (0x401,CC); lsb_done in cycle 3; mem_wr=0 otherwise.
REQ-031 Abort: clear pulsed in cycle 3 of an IF word fetch -> no if_done; IDLE in cycle 4.
  - Same clear during a word store -> store completes, lsb_done in cycle 5.
REQ-032 Stall and reset: rdy_in low for cycles 2-4 of a word load -> lsb_done delayed to cycle 9, data correct.
  - rst_in low mid-transfer -> all outputs 0 immediately, no done pulse.
REQ-033 MEM_CTRL_IO_STALL_EN defined, io_buffer_full=1, store to 0x30000 -> not accepted; io_buffer_full falls in cycle 5 -> accepted cycle 5, lsb_done cycle 7.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter serving instruction fetch (IF) and the load/store buffer (LSB).
// Optional MEM_CTRL_IO_STALL_EN holds back UART stores (0x30000/0x30004) while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    state_t      state_r, state_nxt_s;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic [2:0]  n_r, n_nxt_s;
    logic        is_lsb_r, is_lsb_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic [31:0] buf_r, buf_nxt_s;
    logic [31:0] mem_a_r, mem_a_nxt_s;
    logic [7:0]  mem_dout_r, mem_dout_nxt_s;
    logic        mem_wr_r, mem_wr_nxt_s;
    logic        if_done_r, if_done_nxt_s;
    logic        lsb_done_r, lsb_done_nxt_s;
    logic [31:0] if_data_r, if_data_nxt_s;
    logic [31:0] lsb_rdata_r, lsb_rdata_nxt_s;

    logic        lsb_block_s, lsb_go_s, if_go_s;
    logic [2:0]  lsb_n_s;
    logic [31:0] merged_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] word, input logic [7:0] b,
                                               input logic [1:0] idx);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

`ifdef MEM_CTRL_IO_STALL_EN
    assign lsb_block_s = io_buffer_full && lsb_wr &&
                         ((lsb_addr == 32'h0003_0000) || (lsb_addr == 32'h0003_0004));
`else
    logic unused_io_full_s;
    assign unused_io_full_s = io_buffer_full;
    assign lsb_block_s      = 1'b0;
`endif

    // A blocked UART store lets IF through; otherwise the LSB has priority.
    assign lsb_go_s = lsb_req && !lsb_block_s;
    assign if_go_s  = if_req && !lsb_go_s;

    // In cycle c of a read, cnt_r = c-1, so byte cnt_r-1 is on mem_din.
    assign merged_s = byte_merge(buf_r, mem_din, cnt_r[1:0] - 2'd1);

    // Transfer length decode; length code 3 behaves as a word.
    always_comb begin
        case (lsb_len)
            2'd0:    lsb_n_s = 3'd1;
            2'd1:    lsb_n_s = 3'd2;
            default: lsb_n_s = 3'd4;
        endcase
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        n_nxt_s         = n_r;
        is_lsb_nxt_s    = is_lsb_r;
        wdata_nxt_s     = wdata_r;
        buf_nxt_s       = buf_r;
        mem_a_nxt_s     = mem_a_r;
        mem_dout_nxt_s  = mem_dout_r;
        mem_wr_nxt_s    = mem_wr_r;
        if_done_nxt_s   = if_done_r;
        lsb_done_nxt_s  = lsb_done_r;
        if_data_nxt_s   = if_data_r;
        lsb_rdata_nxt_s = lsb_rdata_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s      = 3'd0;
                buf_nxt_s      = 32'd0;
                mem_wr_nxt_s   = 1'b0;
                if_done_nxt_s  = 1'b0;
                lsb_done_nxt_s = 1'b0;
                if (!clear && lsb_go_s) begin
                    is_lsb_nxt_s = 1'b1;
                    n_nxt_s      = lsb_n_s;
                    mem_a_nxt_s  = lsb_addr;
                    wdata_nxt_s  = lsb_wdata;
                    if (lsb_wr) begin
                        state_nxt_s    = WRITE;
                        mem_wr_nxt_s   = 1'b1;
                        mem_dout_nxt_s = lsb_wdata[7:0];
                    end else begin
                        state_nxt_s = READ;
                    end
                end else if (!clear && if_go_s) begin
                    is_lsb_nxt_s = 1'b0;
                    n_nxt_s      = 3'd4;
                    mem_a_nxt_s  = if_addr;
                    state_nxt_s  = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (clear || (cnt_r > n_r)) begin
                    state_nxt_s    = IDLE;
                    cnt_nxt_s      = 3'd0;
                    if_done_nxt_s  = 1'b0;
                    lsb_done_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + 3'd1;
                    if (cnt_r + 3'd1 < n_r) begin
                        mem_a_nxt_s = mem_a_r + 32'd1;
                    end else begin
                        mem_a_nxt_s = mem_a_r;
                    end
                    if (cnt_r != 3'd0) begin
                        buf_nxt_s = merged_s;
                    end else begin
                        buf_nxt_s = buf_r;
                    end
                    if (cnt_r == n_r) begin
                        if (is_lsb_r) begin
                            lsb_done_nxt_s  = 1'b1;
                            lsb_rdata_nxt_s = merged_s;
                        end else begin
                            if_done_nxt_s = 1'b1;
                            if_data_nxt_s = merged_s;
                        end
                    end else begin
                        if_done_nxt_s  = 1'b0;
                        lsb_done_nxt_s = 1'b0;
                    end
                end
            end
            WRITE: begin
                // clear is deliberately ignored: a started store always completes.
                cnt_nxt_s = cnt_r + 3'd1;
                if (cnt_r + 3'd1 < n_r) begin
                    mem_a_nxt_s    = mem_a_r + 32'd1;
                    mem_dout_nxt_s = byte_sel(wdata_r, cnt_r[1:0] + 2'd1);
                    mem_wr_nxt_s   = 1'b1;
                end else if (cnt_r + 3'd1 == n_r) begin
                    mem_wr_nxt_s   = 1'b0;
                    lsb_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s    = IDLE;
                    cnt_nxt_s      = 3'd0;
                    mem_wr_nxt_s   = 1'b0;
                    lsb_done_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                cnt_nxt_s      = 3'd0;
                mem_wr_nxt_s   = 1'b0;
                if_done_nxt_s  = 1'b0;
                lsb_done_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            n_r         <= 3'd0;
            is_lsb_r    <= 1'b0;
            wdata_r     <= 32'd0;
            buf_r       <= 32'd0;
            mem_a_r     <= 32'd0;
            mem_dout_r  <= 8'd0;
            mem_wr_r    <= 1'b0;
            if_done_r   <= 1'b0;
            lsb_done_r  <= 1'b0;
            if_data_r   <= 32'd0;
            lsb_rdata_r <= 32'd0;
        end else if (rdy_in) begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            n_r         <= n_nxt_s;
            is_lsb_r    <= is_lsb_nxt_s;
            wdata_r     <= wdata_nxt_s;
            buf_r       <= buf_nxt_s;
            mem_a_r     <= mem_a_nxt_s;
            mem_dout_r  <= mem_dout_nxt_s;
            mem_wr_r    <= mem_wr_nxt_s;
            if_done_r   <= if_done_nxt_s;
            lsb_done_r  <= lsb_done_nxt_s;
            if_data_r   <= if_data_nxt_s;
            lsb_rdata_r <= lsb_rdata_nxt_s;
        end
    end

    assign mem_wr    = mem_wr_r && rdy_in;
    assign mem_a     = mem_a_r;
    assign mem_dout  = mem_dout_r;
    assign if_done   = if_done_r;
    assign if_data   = if_data_r;
    assign lsb_done  = lsb_done_r;
    assign lsb_rdata = lsb_rdata_r;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table plus hand sequences for abort, stall and reset.
// Set MEM_CTRL_IO_STALL_EN to exercise the UART store hold-off.
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        if_req, if_done, lsb_req, lsb_wr, lsb_done, mem_wr, io_buffer_full;
    logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        logic        is_if;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        int          lat;
    } vec_t;

    vec_t        vecs [11];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          last_if_cyc = -100;
    int          last_lsb_cyc = -100;
    logic [31:0] a_log [0:1023];
    logic [31:0] if_q [$];
    logic [31:0] lsb_q [$];
    logic [39:0] wr_q [$];
    logic [31:0] exp_if_hold = 32'd0;
    logic [31:0] exp_lsb_hold = 32'd0;

    // RAM contents: the spec bytes at 0x100..0x103 and 0x200, a hash elsewhere.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h00;
            32'h102: return 8'h00;
            32'h103: return 8'h93;
            32'h200: return 8'hFF;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr, input int nb);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = ram_byte(addr + 32'(i));
        return r;
    endfunction

    function automatic int nbytes(input vec_t v);
        if (v.is_if) return 4;
        if (v.len == 2'd0) return 1;
        if (v.len == 2'd1) return 2;
        return 4;
    endfunction

    // Synchronous RAM, enabled by rdy_in like the rest of the system.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= ram_byte(mem_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, score them, then advance to the next cycle.
    task automatic cyc();
        logic [39:0] w;
        #1;
        if (cyc_n < 1024) a_log[cyc_n] = mem_a;
        if (!rdy_in) check("stall_mem_wr", 32'(mem_wr), 32'd0);
        if (wr_q.size() == 0) begin
            check("mem_wr_idle", 32'(mem_wr), 32'd0);
        end else if (mem_wr) begin
            w = wr_q.pop_front();
            check("wr_addr", mem_a, w[39:8]);
            check("wr_data", 32'(mem_dout), 32'(w[7:0]));
        end
        if (if_q.size() == 0) begin
            check("if_done_idle", 32'(if_done), 32'd0);
        end else if (if_done) begin
            check("if_data", if_data, if_q.pop_front());
            last_if_cyc = cyc_n;
            if_req = 1'b0;
        end
        if (lsb_q.size() == 0) begin
            check("lsb_done_idle", 32'(lsb_done), 32'd0);
        end else if (lsb_done) begin
            check("lsb_rdata", lsb_rdata, lsb_q.pop_front());
            last_lsb_cyc = cyc_n;
            lsb_req = 1'b0;
        end
        @(posedge clk_in);
        #1;
        cyc_n++;
    endtask

    task automatic wait_done(input logic is_if, input int t0, input int lat, input string name);
        for (int k = 0; k < 24; k++) begin
            cyc();
            if (is_if ? (last_if_cyc >= t0) : (last_lsb_cyc >= t0)) break;
        end
        check({name, "_latency"}, 32'((is_if ? last_if_cyc : last_lsb_cyc) - t0), 32'(lat));
    endtask

    // Drive one request from the current cycle and register what must come back.
    task automatic start_req(input vec_t v);
        int nb;
        nb = nbytes(v);
        if (v.is_if) begin
            if_req = 1'b1;
            if_addr = v.addr;
            exp_if_hold = exp_read(v.addr, 4);
            if_q.push_back(exp_if_hold);
        end else begin
            lsb_req = 1'b1;
            lsb_wr = v.wr;
            lsb_addr = v.addr;
            lsb_len = v.len;
            lsb_wdata = v.wdata;
            if (v.wr) begin
                for (int i = 0; i < nb; i++) wr_q.push_back({v.addr + 32'(i), v.wdata[8*i +: 8]});
            end else begin
                exp_lsb_hold = exp_read(v.addr, nb);
            end
            lsb_q.push_back(exp_lsb_hold);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_mem_a"}, mem_a, 32'd0);
        check({name, "_mem_dout"}, 32'(mem_dout), 32'd0);
        check({name, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({name, "_if_done"}, 32'(if_done), 32'd0);
        check({name, "_lsb_done"}, 32'(lsb_done), 32'd0);
        check({name, "_if_data"}, if_data, 32'd0);
        check({name, "_lsb_rdata"}, lsb_rdata, 32'd0);
    endtask

    initial begin
        int   t0, nb;
        vec_t v;
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'h0, 6};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0200, 2'd0, 32'h0, 3};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0102, 2'd1, 32'h0, 4};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0037, 2'd2, 32'h0, 6};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0050, 2'd3, 32'h0, 6};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 2'd0, 32'h1122_3344, 2};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 2'd1, 32'hAABB_CCDD, 3};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 2'd2, 32'hDEAD_BEEF, 5};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, 6};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 2'd2, 32'h0BAD_F00D, 5};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFD, 2'd2, 32'h0, 6};

        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; lsb_req = 1'b0; lsb_wr = 1'b0;
        lsb_addr = 32'd0; lsb_len = 2'd0; lsb_wdata = 32'd0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        rst_in = 1'b1;

        for (int i = 0; i < 11; i++) begin
            t0 = cyc_n;
            start_req(vecs[i]);
            wait_done(vecs[i].is_if, t0, vecs[i].lat, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_wr_left", i), 32'(wr_q.size()), 32'd0);
            if (!vecs[i].wr) begin
                nb = nbytes(vecs[i]);
                for (int b = 0; b < nb; b++)
                    check($sformatf("vec%0d_mem_a%0d", i, b), a_log[t0 + 1 + b], vecs[i].addr + 32'(b));
            end
        end
        check("if_data_hold", if_data, exp_if_hold);
        check("lsb_rdata_hold", lsb_rdata, exp_lsb_hold);

        // LSB wins a tie; IF is taken the cycle after lsb_done.
        t0 = cyc_n;
        v = '{1'b0, 1'b0, 32'h0000_0200, 2'd0, 32'h0, 3};
        start_req(v);
        v = '{1'b1, 1'b0, 32'h0000_0104, 2'd2, 32'h0, 10};
        start_req(v);
        wait_done(1'b1, t0, 10, "concurrent_if");
        check("concurrent_lsb_latency", 32'(last_lsb_cyc - t0), 32'd3);
        check("concurrent_if_mem_a", a_log[t0 + 5], 32'h0000_0104);

        // clear in IDLE defers acceptance by one cycle.
        t0 = cyc_n;
        clear = 1'b1;
        v = '{1'b0, 1'b0, 32'h0000_0201, 2'd0, 32'h0, 4};
        start_req(v);
        cyc();
        clear = 1'b0;
        wait_done(1'b0, t0, 4, "clear_idle");

        // clear in cycle 3 of a fetch aborts it; an LSB load is taken in cycle 4.
        t0 = cyc_n;
        v = '{1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'h0, 6};
        exp_lsb_hold = exp_lsb_hold;
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        repeat (3) cyc();
        clear = 1'b1;
        if_req = 1'b0;
        cyc();
        clear = 1'b0;
        v = '{1'b0, 1'b0, 32'h0000_0203, 2'd0, 32'h0, 3};
        start_req(v);
        wait_done(1'b0, t0 + 4, 3, "abort_then_load");
        repeat (4) cyc();
        check("abort_no_if_done", 32'(last_if_cyc >= t0), 32'd0);
        check("abort_if_data_hold", if_data, exp_if_hold);

        // clear during a word store is ignored.
        t0 = cyc_n;
        v = '{1'b0, 1'b1, 32'h0000_0040, 2'd2, 32'h1234_5678, 5};
        start_req(v);
        repeat (3) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        wait_done(1'b0, t0, 5, "clear_store");
        check("clear_store_wr_left", 32'(wr_q.size()), 32'd0);

        // rdy_in low in cycles 2-4 of a word load delays done to cycle 9.
        t0 = cyc_n;
        v = '{1'b0, 1'b0, 32'h0000_0300, 2'd2, 32'h0, 9};
        start_req(v);
        repeat (2) cyc();
        rdy_in = 1'b0;
        repeat (3) cyc();
        rdy_in = 1'b1;
        wait_done(1'b0, t0, 9, "stall_load");

        // rdy_in low in cycles 2-3 of a word store: mem_wr masked, done in cycle 7.
        t0 = cyc_n;
        v = '{1'b0, 1'b1, 32'h0000_0500, 2'd2, 32'hCAFE_F00D, 7};
        start_req(v);
        repeat (2) cyc();
        rdy_in = 1'b0;
        repeat (2) cyc();
        rdy_in = 1'b1;
        wait_done(1'b0, t0, 7, "stall_store");
        check("stall_store_wr_left", 32'(wr_q.size()), 32'd0);

        // Reset in the middle of a fetch: outputs drop at once, no done pulse.
        t0 = cyc_n;
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        repeat (3) cyc();
        rst_in = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        if_req = 1'b0;
        exp_if_hold = 32'd0;
        exp_lsb_hold = 32'd0;
        repeat (2) cyc();
        rst_in = 1'b1;
        check("reset_no_if_done", 32'(last_if_cyc >= t0), 32'd0);
        t0 = cyc_n;
        v = '{1'b0, 1'b0, 32'h0000_0200, 2'd0, 32'h0, 3};
        start_req(v);
        wait_done(1'b0, t0, 3, "after_reset");

        // UART store with io_buffer_full high until cycle 5.
        t0 = cyc_n;
        io_buffer_full = 1'b1;
        v = '{1'b0, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_005A, 7};
        start_req(v);
`ifdef MEM_CTRL_IO_STALL_EN
        repeat (5) cyc();
        io_buffer_full = 1'b0;
        wait_done(1'b0, t0, 7, "io_stall");
`else
        wait_done(1'b0, t0, 2, "io_ignored");
        io_buffer_full = 1'b0;
`endif
        check("io_wr_left", 32'(wr_q.size()), 32'd0);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
